// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for mem_responder: FSM states, opcodes, line and address types
// No ports; imported by the interface, the top and the testbench.
`include "mem_handle.vh"
package mem_pkg;
  localparam int ADDR_W      = `ADDR_SIZE;
  localparam int CACHE_WORDS = `CACHE_BITS;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CACHE_WORDS-1:0][31:0] line_t;

  typedef enum logic [2:0] {IDLE, XFER, DRAIN, DONE, RELEASE} state_t;
  typedef enum logic [1:0] {OP_W_LINE, OP_R_LINE, OP_W_ONE, OP_R_ONE} op_t;

  function automatic logic op_is_write(op_t op);
    return (op == OP_W_LINE) || (op == OP_W_ONE);
  endfunction

  function automatic logic op_is_line(op_t op);
    return (op == OP_W_LINE) || (op == OP_R_LINE);
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bundle between an initiator and mem_responder
// master: drives the four request strobes, mem_addr and line_store; sees line_read, mem_ready, mem_done.
// slave:  the responder side of the same signals.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int LINE_WORDS = CACHE_WORDS
);
  logic                        mem_w_line;
  logic                        mem_r_line;
  logic                        mem_w_one;
  logic                        mem_r_one;
  addr_t                       mem_addr;
  logic [LINE_WORDS-1:0][31:0] line_store;
  logic [LINE_WORDS-1:0][31:0] line_read;
  logic                        mem_ready;
  logic                        mem_done;

  modport master (
    output mem_w_line, mem_r_line, mem_w_one, mem_r_one, mem_addr, line_store,
    input  line_read, mem_ready, mem_done
  );

  modport slave (
    input  mem_w_line, mem_r_line, mem_w_one, mem_r_one, mem_addr, line_store,
    output line_read, mem_ready, mem_done
  );
endinterface

// File: rtl/mem_handle.vh
// rtl/mem_handle.vh - shared address-width and line-size macros for the memory handle
`ifndef MEM_HANDLE_VH
`define MEM_HANDLE_VH
`define ADDR_SIZE 32
`define CACHE_BITS 4
`endif

// File: rtl/mem_sram.sv
// rtl/mem_sram.sv - single-port DEPTH x 32 SRAM, synchronous read with one cycle latency, no reset
// Ports: clk; we write enable; addr word index; wdata write word; rdata registered read word.
module mem_sram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // Read-first: a write cycle returns the old word, which the responder never consumes.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - line / single-word memory responder in front of a one-port SRAM
// Ports: clk rising-edge clock; rst synchronous active-high reset;
//        bus (slave) carries request strobes, address, write line, read line, mem_ready, mem_done.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int LINE_WORDS = CACHE_WORDS
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CW-1:0] LAST_LINE = CW'(LINE_WORDS - 1);
  localparam logic [AW-1:0] LINE_MASK = ~AW'(LINE_WORDS - 1);

  state_t        state, state_n;
  op_t           op_q, op_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rd_pend;
  logic [CW-1:0] rd_idx;
  logic          any_req;
  logic          xfer_last;
  logic          sram_we, sram_re;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic [LINE_WORDS-1:0][31:0] line_q;

  assign any_req   = bus.mem_w_line | bus.mem_r_line | bus.mem_w_one | bus.mem_r_one;
  assign xfer_last = (cnt == (op_is_line(op_q) ? LAST_LINE : '0));

  // Only the low AW bits of the address are kept: that is the modulo-DEPTH wrap.
  always_comb begin
    state_n    = state;
    op_n       = op_q;
    addr_n     = addr_q;
    cnt_n      = cnt;
    sram_we    = 1'b0;
    sram_re    = 1'b0;
    sram_addr  = addr_q + AW'(cnt);
    sram_wdata = bus.line_store[cnt];
    case (state)
      IDLE: begin
        if (any_req) begin
          if (bus.mem_w_line)      op_n = OP_W_LINE;
          else if (bus.mem_r_line) op_n = OP_R_LINE;
          else if (bus.mem_w_one)  op_n = OP_W_ONE;
          else                     op_n = OP_R_ONE;
          addr_n  = op_is_line(op_n) ? (bus.mem_addr[AW-1:0] & LINE_MASK) : bus.mem_addr[AW-1:0];
          cnt_n   = '0;
          state_n = XFER;
        end
      end
      XFER: begin
        sram_we = op_is_write(op_q);
        sram_re = ~op_is_write(op_q);
        if (xfer_last) state_n = op_is_write(op_q) ? DONE : DRAIN;
        else           cnt_n   = cnt + 1'b1;
      end
      DRAIN:   state_n = DONE;
      DONE:    state_n = RELEASE;
      // Hold here until the initiator drops every strobe so a held one cannot retrigger.
      RELEASE: if (!any_req) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_W_LINE;
      addr_q  <= '0;
      cnt     <= '0;
      rd_pend <= 1'b0;
      rd_idx  <= '0;
      line_q  <= '0;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      addr_q  <= addr_n;
      cnt     <= cnt_n;
      // SRAM data for the word issued last cycle lands now; only that element is touched.
      rd_pend <= sram_re;
      rd_idx  <= cnt;
      if (rd_pend) line_q[rd_idx] <= sram_rdata;
    end
  end

  mem_sram #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  assign bus.line_read = line_q;
  assign bus.mem_ready = (state == IDLE);
  assign bus.mem_done  = (state == DONE);
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;
  import mem_pkg::*;

  localparam int LW = 4;
  typedef logic [LW-1:0][31:0] lw_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if #(.LINE_WORDS(LW)) bus ();

  mem_responder #(.DEPTH(4096), .LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // strb = {w_line, r_line, w_one, r_one}; entered #1 after a rising edge with the DUT idle.
  task automatic do_op(input logic [3:0] strb, input logic [31:0] addr, input lw_t data,
                       output int lat, output int ready_hi, output logic done_after, output lw_t rd);
    lat = -1; ready_hi = 0; done_after = 1'b0; rd = '0;
    bus.mem_addr   = addr_t'(addr);
    bus.line_store = data;
    {bus.mem_w_line, bus.mem_r_line, bus.mem_w_one, bus.mem_r_one} = strb;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.mem_addr = addr_t'(addr ^ 32'h100);
      if (bus.mem_ready) ready_hi++;
      if (bus.mem_done) begin lat = c; rd = bus.line_read; end
    end
    {bus.mem_w_line, bus.mem_r_line, bus.mem_w_one, bus.mem_r_one} = 4'b0000;
    @(posedge clk); #1;
    done_after = bus.mem_done;
    for (int c = 0; c < 5 && !bus.mem_ready; c++) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {bus.mem_w_line, bus.mem_r_line, bus.mem_w_one, bus.mem_r_one} = 4'b0000;
    bus.mem_addr = '0; bus.line_store = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (bus.mem_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.mem_ready); end
    n_cmp++; if (bus.mem_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.mem_done); end
    n_cmp++; if (bus.line_read !== lw_t'(0)) begin n_bad++; $display("FAIL reset_line: got %h want 0", bus.line_read); end
  endtask

  task automatic test_line_write_read();
    int lat, rh; logic da; lw_t rd;
    do_op(4'b1000, 32'h13, lw_t'({32'hD, 32'hC, 32'hB, 32'hA}), lat, rh, da, rd);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL wline_latency: got %0d want 5", lat); end
    n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL wline_done_width: got %b want 0", da); end
    do_op(4'b0100, 32'h11, '0, lat, rh, da, rd);
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL rline_latency: got %0d want 6", lat); end
    n_cmp++; if (rd !== lw_t'({32'hD, 32'hC, 32'hB, 32'hA})) begin n_bad++; $display("FAIL rline_data: got %h want 0000000d0000000c0000000b0000000a", rd); end
    n_cmp++; if (rh !== 0) begin n_bad++; $display("FAIL rline_ready_low: got %0d ready cycles want 0", rh); end
    n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL rline_done_width: got %b want 0", da); end
  endtask

  task automatic test_single();
    int lat, rh; logic da; lw_t rd;
    do_op(4'b0010, 32'h12, lw_t'({32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'h55}), lat, rh, da, rd);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wone_latency: got %0d want 2", lat); end
    n_cmp++; if (bus.line_read !== lw_t'({32'hD, 32'hC, 32'hB, 32'hA})) begin n_bad++; $display("FAIL wone_line_hold: got %h want 0000000d0000000c0000000b0000000a", bus.line_read); end
    do_op(4'b0001, 32'h12, '0, lat, rh, da, rd);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rone_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== lw_t'({32'hD, 32'hC, 32'hB, 32'h55})) begin n_bad++; $display("FAIL rone_data: got %h want 0000000d0000000c0000000b00000055", rd); end
    do_op(4'b0100, 32'h10, '0, lat, rh, da, rd);
    n_cmp++; if (rd !== lw_t'({32'hD, 32'h55, 32'hB, 32'hA})) begin n_bad++; $display("FAIL wone_one_word_only: got %h want 0000000d000000550000000b0000000a", rd); end
  endtask

  task automatic test_priority_release();
    int lat, rh; logic da; lw_t rd;
    logic got_done, got_ready;
    lat = -1;
    bus.mem_addr = addr_t'(32'h20);
    bus.line_store = lw_t'({32'h4, 32'h3, 32'h2, 32'h1});
    bus.mem_w_line = 1'b1; bus.mem_r_one = 1'b1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (bus.mem_done) lat = c;
    end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL prio_latency: got %0d want 5", lat); end
    n_cmp++; if (bus.line_read !== lw_t'({32'hD, 32'h55, 32'hB, 32'hA})) begin n_bad++; $display("FAIL prio_no_read: got %h want 0000000d000000550000000b0000000a", bus.line_read); end
    bus.mem_w_line = 1'b0;
    got_done = 1'b0; got_ready = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.mem_done) got_done = 1'b1;
      if (bus.mem_ready) got_ready = 1'b1;
    end
    n_cmp++; if (got_done !== 1'b0) begin n_bad++; $display("FAIL release_retrigger: got done=%b want 0", got_done); end
    n_cmp++; if (got_ready !== 1'b0) begin n_bad++; $display("FAIL release_hold: got ready=%b want 0", got_ready); end
    bus.mem_r_one = 1'b0;
    for (int c = 0; c < 4 && !bus.mem_ready; c++) begin @(posedge clk); #1; end
    n_cmp++; if (bus.mem_ready !== 1'b1) begin n_bad++; $display("FAIL release_exit: got ready=%b want 1", bus.mem_ready); end
    do_op(4'b0100, 32'h22, '0, lat, rh, da, rd);
    n_cmp++; if (rd !== lw_t'({32'h4, 32'h3, 32'h2, 32'h1})) begin n_bad++; $display("FAIL prio_line_data: got %h want 00000004000000030000000200000001", rd); end
  endtask

  task automatic test_reset_mid();
    int lat, rh; logic da; lw_t rd;
    logic got_done;
    bus.mem_addr = addr_t'(32'h30);
    bus.line_store = lw_t'({32'h34, 32'h33, 32'h32, 32'h31});
    bus.mem_w_line = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_w_line = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (bus.mem_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", bus.mem_ready); end
    n_cmp++; if (bus.line_read !== lw_t'(0)) begin n_bad++; $display("FAIL abort_line_clear: got %h want 0", bus.line_read); end
    got_done = bus.mem_done;
    repeat (4) begin @(posedge clk); #1; if (bus.mem_done) got_done = 1'b1; end
    n_cmp++; if (got_done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b want 0", got_done); end
    do_op(4'b0001, 32'h30, '0, lat, rh, da, rd);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL abort_rone_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== lw_t'({32'h0, 32'h0, 32'h0, 32'h31})) begin n_bad++; $display("FAIL abort_rone_data: got %h want 00000031 in element 0 only", rd); end
  endtask

  task automatic test_wrap();
    int lat, rh; logic da; lw_t rd;
    do_op(4'b0010, 32'h1005, lw_t'({32'h0, 32'h0, 32'h0, 32'h77}), lat, rh, da, rd);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wrap_wone_latency: got %0d want 2", lat); end
    do_op(4'b0001, 32'h005, '0, lat, rh, da, rd);
    n_cmp++; if (rd[0] !== 32'h77) begin n_bad++; $display("FAIL wrap_data: got %h want 00000077", rd[0]); end
  endtask

  initial begin
    test_reset();
    test_line_write_read();
    test_single();
    test_priority_release();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
